// File: rtl/vlan_pkg.sv
// Shared types for the VLAN ingress buffer: bus bundle, metadata entry,
// receive FSM states and a lane-count helper.
package vlan_pkg;

    typedef struct packed {
        logic        start;
        logic        data_valid;
        logic [1:0]  bytes_valid;
        logic [31:0] data;
        logic        commit;
        logic        drop;
    } eth_rx_bus_t;

    typedef struct packed {
        logic [11:0] vlan;
        logic [10:0] len;
        logic [47:0] dst_mac;
    } vlan_meta_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECEIVE,
        ST_DISCARD
    } rx_state_e;

    localparam int unsigned RUNT_BYTES = 14;

    // A bytes_valid of zero marks a full 4-byte word.
    function automatic logic [2:0] lane_bytes(input logic [1:0] bv);
        return (bv == 2'd0) ? 3'd4 : {1'b0, bv};
    endfunction

endpackage

// File: rtl/frame_buffer_ram.sv
// Simple dual-port frame RAM: one write port, one registered read port.
module frame_buffer_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/vlan_ingress_buffer.sv
// Ingress frame buffer behind the VLAN untagger: stores whole frames,
// rolls back failed ones and publishes per-frame metadata.
module vlan_ingress_buffer
    import vlan_pkg::*;
#(
    parameter int DATA_DEPTH      = 1024,
    parameter int META_DEPTH      = 32,
    parameter int MAX_FRAME_WORDS = 381
) (
    input  logic        clk,
    input  logic        rst_n,
    input  eth_rx_bus_t in_bus,
    input  logic [11:0] in_vlan,
    output logic        meta_valid,
    output logic [11:0] meta_vlan,
    output logic [10:0] meta_len,
    output logic [47:0] meta_dst_mac,
    input  logic        meta_pop,
    input  logic        rd_en,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic [31:0] drop_count
);

    localparam int AW  = $clog2(DATA_DEPTH);
    localparam int PW  = AW + 1;
    localparam int MW  = $clog2(META_DEPTH);
    localparam int MPW = MW + 1;
    localparam int WCW = $clog2(MAX_FRAME_WORDS + 1);

    rx_state_e      state_q, state_d;
    logic [PW-1:0]  wr_commit_q, wr_commit_d;
    logic [PW-1:0]  wr_tent_q, wr_tent_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [WCW-1:0] word_cnt_q, word_cnt_d;
    logic [10:0]    byte_cnt_q, byte_cnt_d;
    logic [47:0]    dst_mac_q, dst_mac_d;
    logic [31:0]    drop_count_q, drop_count_d;
    logic [MPW-1:0] meta_wr_q, meta_wr_d;
    logic [MPW-1:0] meta_rd_q, meta_rd_d;
    logic           rd_valid_q, rd_valid_d;

    logic           ram_we;
    logic           drop_inc;
    logic           meta_push;
    logic           meta_full;
    logic           data_full;
    logic           frame_max;
    logic           rd_accept;
    logic [11:0]    byte_sum;
    logic [10:0]    byte_next;
    logic [MPW-1:0] meta_cnt;
    vlan_meta_t     meta_entry;
    vlan_meta_t     meta_head;
    vlan_meta_t     meta_mem [META_DEPTH];

    assign data_full = (wr_tent_q - rd_ptr_q) == PW'(DATA_DEPTH);
    assign frame_max = word_cnt_q == WCW'(MAX_FRAME_WORDS);
    assign meta_cnt  = meta_wr_q - meta_rd_q;
    assign meta_full = meta_cnt == MPW'(META_DEPTH);
    assign meta_valid = meta_cnt != '0;

    assign byte_sum  = 12'(byte_cnt_q)
                     + 12'(lane_bytes(in_bus.bytes_valid));
    assign byte_next = byte_sum[11] ? 11'h7ff : byte_sum[10:0];

    // A start cycle only opens a frame; payload follows on later cycles.
    always_comb begin
        state_d     = state_q;
        wr_commit_d = wr_commit_q;
        wr_tent_d   = wr_tent_q;
        word_cnt_d  = word_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        dst_mac_d   = dst_mac_q;
        ram_we      = 1'b0;
        drop_inc    = 1'b0;
        meta_push   = 1'b0;
        unique case (state_q)
            ST_RECEIVE: begin
                if (in_bus.start) begin
                    wr_tent_d  = wr_commit_q;
                    word_cnt_d = '0;
                    byte_cnt_d = '0;
                    drop_inc   = 1'b1;
                end else if (in_bus.drop) begin
                    wr_tent_d = wr_commit_q;
                    state_d   = ST_IDLE;
                end else if (in_bus.data_valid && (data_full || frame_max)) begin
                    wr_tent_d = wr_commit_q;
                    drop_inc  = 1'b1;
                    state_d   = ST_DISCARD;
                end else begin
                    if (in_bus.data_valid) begin
                        ram_we     = 1'b1;
                        wr_tent_d  = wr_tent_q + 1'b1;
                        word_cnt_d = word_cnt_q + 1'b1;
                        byte_cnt_d = byte_next;
                        if (word_cnt_q == WCW'(0)) begin
                            dst_mac_d[47:16] = in_bus.data;
                        end
                        if (word_cnt_q == WCW'(1)) begin
                            dst_mac_d[15:0] = in_bus.data[31:16];
                        end
                    end
                    if (in_bus.commit) begin
                        state_d = ST_IDLE;
                        if (meta_full || byte_cnt_d < 11'(RUNT_BYTES)) begin
                            wr_tent_d = wr_commit_q;
                            drop_inc  = 1'b1;
                        end else begin
                            meta_push   = 1'b1;
                            wr_commit_d = wr_tent_d;
                        end
                    end
                end
            end
            ST_IDLE, ST_DISCARD: begin
                if (in_bus.start) begin
                    wr_tent_d  = wr_commit_q;
                    word_cnt_d = '0;
                    byte_cnt_d = '0;
                    state_d    = ST_RECEIVE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        drop_count_d = drop_count_q;
        if (drop_inc && drop_count_q != '1) begin
            drop_count_d = drop_count_q + 1'b1;
        end
    end

    assign meta_entry = '{vlan: in_vlan, len: byte_cnt_d, dst_mac: dst_mac_d};
    assign meta_head  = meta_mem[meta_rd_q[MW-1:0]];

    always_comb begin
        meta_wr_d = meta_wr_q + MPW'(meta_push);
        meta_rd_d = meta_rd_q + MPW'(meta_pop && meta_valid);
    end

    always_ff @(posedge clk) begin
        if (meta_push) begin
            meta_mem[meta_wr_q[MW-1:0]] <= meta_entry;
        end
    end

    assign rd_accept  = rd_en && (rd_ptr_q != wr_commit_q);
    assign rd_ptr_d   = rd_ptr_q + PW'(rd_accept);
    assign rd_valid_d = rd_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            wr_commit_q  <= '0;
            wr_tent_q    <= '0;
            rd_ptr_q     <= '0;
            word_cnt_q   <= '0;
            byte_cnt_q   <= '0;
            dst_mac_q    <= '0;
            drop_count_q <= '0;
            meta_wr_q    <= '0;
            meta_rd_q    <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_commit_q  <= wr_commit_d;
            wr_tent_q    <= wr_tent_d;
            rd_ptr_q     <= rd_ptr_d;
            word_cnt_q   <= word_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            dst_mac_q    <= dst_mac_d;
            drop_count_q <= drop_count_d;
            meta_wr_q    <= meta_wr_d;
            meta_rd_q    <= meta_rd_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    frame_buffer_ram #(
        .DEPTH (DATA_DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .waddr (wr_tent_q[AW-1:0]),
        .wdata (in_bus.data),
        .re    (rd_accept),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (rd_data)
    );

    // Head fields read as zero whenever the FIFO holds nothing.
    assign meta_vlan    = meta_valid ? meta_head.vlan : '0;
    assign meta_len     = meta_valid ? meta_head.len : '0;
    assign meta_dst_mac = meta_valid ? meta_head.dst_mac : '0;
    assign rd_valid     = rd_valid_q;
    assign drop_count   = drop_count_q;

endmodule

// File: tb/tb_vlan_ingress_buffer.sv
// Bench for vlan_ingress_buffer: directed table, frame-level random model,
// meta-full and reset-mid-frame sequences.
module tb_vlan_ingress_buffer;
    import vlan_pkg::*;

    localparam int DD   = 1024;
    localparam int MD   = 32;
    localparam int MAXW = 381;

    logic        clk = 1'b0;
    logic        rst_n;
    eth_rx_bus_t in_bus;
    logic [11:0] in_vlan;
    logic        meta_valid;
    logic [11:0] meta_vlan;
    logic [10:0] meta_len;
    logic [47:0] meta_dst_mac;
    logic        meta_pop;
    logic        rd_en;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic [31:0] drop_count;

    always #5 clk = ~clk;

    vlan_ingress_buffer #(
        .DATA_DEPTH      (DD),
        .META_DEPTH      (MD),
        .MAX_FRAME_WORDS (MAXW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_bus       (in_bus),
        .in_vlan      (in_vlan),
        .meta_valid   (meta_valid),
        .meta_vlan    (meta_vlan),
        .meta_len     (meta_len),
        .meta_dst_mac (meta_dst_mac),
        .meta_pop     (meta_pop),
        .rd_en        (rd_en),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .drop_count   (drop_count)
    );

    int tests = 0;
    int fails = 0;

    // Reference state: committed unread words, pending metadata, drops.
    logic [31:0] dq[$];
    vlan_meta_t  mq[$];
    int          exp_drop;
    bit          in_frame;
    logic [31:0] fw [0:511];

    typedef struct {
        int          nw;
        int          lastb;
        logic [11:0] vlan;
        int          ending;
        bit          exp_meta;
        int          exp_len;
        int          exp_drop;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [95:0] act,
                       input logic [95:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ending: 0 commit with last word, 1 commit next cycle,
    // 2 drop next cycle, 3 left open (aborted by the next start)
    task automatic run_frame(input int nw, input int lastb,
                             input logic [11:0] vlan, input int ending);
        int bytes;
        int space;
        bit ovf;
        vlan_meta_t m;
        bytes = (nw - 1) * 4 + ((lastb == 0) ? 4 : lastb);
        for (int i = 0; i < nw; i++) fw[i] = $urandom;
        if (in_frame) exp_drop++;
        in_frame = 1'b0;
        space = DD - dq.size();
        ovf = (nw > MAXW) || (nw > space);
        if (ovf) begin
            exp_drop++;
        end else if (ending == 3) begin
            in_frame = 1'b1;
        end else if (ending != 2) begin
            if (bytes < 14 || mq.size() == MD) begin
                exp_drop++;
            end else begin
                m.vlan = vlan;
                m.len = 11'(bytes);
                m.dst_mac = {fw[0], fw[1][31:16]};
                mq.push_back(m);
                for (int i = 0; i < nw; i++) dq.push_back(fw[i]);
            end
        end
        in_vlan = vlan;
        in_bus = '0;
        in_bus.start = 1'b1;
        tick();
        in_bus = '0;
        for (int i = 0; i < nw; i++) begin
            in_bus.data_valid = 1'b1;
            in_bus.data = fw[i];
            in_bus.bytes_valid = (i == nw - 1) ? 2'(lastb) : 2'd0;
            in_bus.commit = (ending == 0) && (i == nw - 1);
            tick();
        end
        in_bus = '0;
        if (ending == 1) begin
            in_bus.commit = 1'b1;
            tick();
        end
        if (ending == 2) begin
            in_bus.drop = 1'b1;
            tick();
        end
        in_bus = '0;
        chk("drop_count", drop_count, exp_drop);
    endtask

    task automatic drain_one;
        vlan_meta_t e;
        int nwd;
        e = mq.pop_front();
        chk("meta_valid", meta_valid, 1);
        chk("meta_vlan", meta_vlan, e.vlan);
        chk("meta_len", meta_len, e.len);
        chk("meta_dst_mac", meta_dst_mac, e.dst_mac);
        nwd = (int'(e.len) + 3) / 4;
        rd_en = 1'b1;
        for (int k = 0; k < nwd; k++) begin
            tick();
            chk("rd_valid", rd_valid, 1);
            chk("rd_data", rd_data, dq.pop_front());
        end
        rd_en = 1'b0;
        meta_pop = 1'b1;
        tick();
        meta_pop = 1'b0;
    endtask

    task automatic drain_all;
        while (mq.size() > 0) drain_one();
        chk("meta_empty", meta_valid, 0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("rd_when_empty", rd_valid, 0);
    endtask

    initial begin
        int base;
        int n;
        tbl[0] = '{16, 0, 12'h05a, 0, 1'b1, 64, 0};
        tbl[1] = '{10, 0, 12'h0b1, 2, 1'b0, 0, 0};
        tbl[2] = '{400, 0, 12'h0c2, 0, 1'b0, 0, 1};
        tbl[3] = '{16, 0, 12'h123, 0, 1'b1, 64, 1};
        tbl[4] = '{3, 1, 12'h0d3, 0, 1'b0, 0, 2};
        tbl[5] = '{4, 2, 12'h0e4, 1, 1'b1, 14, 2};
        tbl[6] = '{4, 1, 12'h0e5, 0, 1'b0, 0, 3};
        tbl[7] = '{5, 0, 12'h0f6, 3, 1'b0, 0, 3};
        tbl[8] = '{25, 0, 12'h0aa, 0, 1'b1, 100, 4};
        tbl[9] = '{381, 3, 12'h0bb, 0, 1'b1, 1523, 4};

        rst_n = 1'b0;
        in_bus = '0;
        in_vlan = '0;
        rd_en = 1'b0;
        meta_pop = 1'b0;
        exp_drop = 0;
        in_frame = 1'b0;
        tick();
        tick();
        chk("rst_meta_valid", meta_valid, 0);
        chk("rst_meta_len", meta_len, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_drop_count", drop_count, 0);
        rst_n = 1'b1;
        tick();

        foreach (tbl[v]) begin
            run_frame(tbl[v].nw, tbl[v].lastb, tbl[v].vlan, tbl[v].ending);
            chk("tbl_drop", drop_count, tbl[v].exp_drop);
            chk("tbl_meta_valid", meta_valid, tbl[v].exp_meta);
            if (tbl[v].exp_meta) begin
                chk("tbl_len", meta_len, tbl[v].exp_len);
                chk("tbl_vlan", meta_vlan, tbl[v].vlan);
            end
            drain_all();
        end

        for (int f = 0; f < 60; f++) begin
            run_frame($urandom_range(1, 40), $urandom_range(0, 3),
                      12'($urandom), $urandom_range(0, 3));
            chk("rnd_meta_valid", meta_valid, mq.size() > 0);
            if ($urandom_range(0, 2) == 0) begin
                n = $urandom_range(1, 3);
                for (int k = 0; k < n; k++) begin
                    if (mq.size() > 0) drain_one();
                end
            end
        end
        run_frame(16, 0, 12'h321, 0);
        drain_all();

        base = exp_drop;
        for (int f = 0; f < 33; f++) begin
            run_frame(15, 0, 12'(f), 0);
        end
        chk("meta_full_drop", drop_count, base + 1);
        drain_all();

        for (int f = 0; f < 3; f++) run_frame(16, 0, 12'h0c0, 0);
        run_frame(5, 0, 12'h0c1, 3);
        rst_n = 1'b0;
        #2;
        chk("midrst_meta_valid", meta_valid, 0);
        chk("midrst_rd_valid", rd_valid, 0);
        chk("midrst_drop_count", drop_count, 0);
        tick();
        rst_n = 1'b1;
        mq.delete();
        dq.delete();
        exp_drop = 0;
        in_frame = 1'b0;
        tick();
        run_frame(16, 0, 12'h05a, 0);
        drain_all();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
